// File: rtl/clk_for_d0_gen.sv
// Divided square-wave generator: o has period 2*DIV clk cycles, tick pulses on each o rise.
// Optional runtime half-period via CLK_FOR_D0_RUNTIME_DIV_EN (adds div_half port and shadow register).
module clk_for_d0_gen #(
    parameter int unsigned DIV   = 25_000_000,
    parameter int unsigned CNT_W = 25
) (
    input  logic             clk,
    input  logic             clr_n,
`ifdef CLK_FOR_D0_RUNTIME_DIV_EN
    input  logic [CNT_W-1:0] div_half,
`endif
    output logic             o,
    output logic             tick
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_o;
    logic             r_tick;
    logic [CNT_W-1:0] w_act;
    logic             w_wrap;

`ifdef CLK_FOR_D0_RUNTIME_DIV_EN
    logic [CNT_W-1:0] r_act;

    // Shadow divisor only reloads at a half-period boundary so no runt pulse is produced.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_act <= CNT_W'(DIV);
        end else if (w_wrap) begin
            r_act <= (div_half == '0) ? CNT_W'(1) : div_half;
        end
    end

    assign w_act = r_act;
`else
    assign w_act = CNT_W'(DIV);
`endif

    assign w_wrap = (r_cnt == (w_act - CNT_W'(1)));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt  <= '0;
            r_o    <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_cnt <= '0;
                r_o   <= ~r_o;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_tick <= w_wrap && !r_o;
        end
    end

    assign o    = r_o;
    assign tick = r_tick;

endmodule

// File: tb/tb_clk_for_d0_gen.sv
// Directed bench for clk_for_d0_gen: DIV=4, DIV=1 and DIV=5 instances share clock and reset.
module tb_clk_for_d0_gen;

    logic clk;
    logic clr_n;
    logic o4, t4, o1, t1, o5, t5;
    logic [3:0] dh4;
    logic [3:0] dh1;
    logic [3:0] dh5;

    int n_tests;
    int n_fail;

    clk_for_d0_gen #(.DIV(4), .CNT_W(4)) u4 (
        .clk(clk), .clr_n(clr_n),
`ifdef CLK_FOR_D0_RUNTIME_DIV_EN
        .div_half(dh4),
`endif
        .o(o4), .tick(t4)
    );

    clk_for_d0_gen #(.DIV(1), .CNT_W(4)) u1 (
        .clk(clk), .clr_n(clr_n),
`ifdef CLK_FOR_D0_RUNTIME_DIV_EN
        .div_half(dh1),
`endif
        .o(o1), .tick(t1)
    );

    clk_for_d0_gen #(.DIV(5), .CNT_W(4)) u5 (
        .clk(clk), .clr_n(clr_n),
`ifdef CLK_FOR_D0_RUNTIME_DIV_EN
        .div_half(dh5),
`endif
        .o(o5), .tick(t5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    logic exp_o4 [1:12];
    logic exp_t4 [1:12];
    logic exp_ro [3:13];
    logic exp_rt [3:13];
    int   n_rise, n_tick, n_high;
    logic prev_o;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        dh4 = 4'd4;
        dh1 = 4'd1;
        dh5 = 4'd5;
        exp_o4 = '{0,0,0,1,1,1,1,0,0,0,0,1};
        exp_t4 = '{0,0,0,1,0,0,0,0,0,0,0,1};

        // Reset held for 3 edges: nothing moves.
        clr_n = 1'b0;
        for (int i = 0; i < 3; i++) edge_sample();
        check("rst_o4", o4, 1'b0);
        check("rst_t4", t4, 1'b0);
        check("rst_o1", o1, 1'b0);
        check("rst_t1", t1, 1'b0);

        // Basic divide DIV=4 and minimum divide DIV=1.
        @(negedge clk);
        clr_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            edge_sample();
            check($sformatf("div4_o_e%0d", k), o4, exp_o4[k]);
            check($sformatf("div4_t_e%0d", k), t4, exp_t4[k]);
            check($sformatf("div1_o_e%0d", k), o1, logic'(k % 2));
            check($sformatf("div1_t_e%0d", k), t1, logic'(k % 2));
        end

        // Async reset mid-cycle while o=1 and cnt=2.
        edge_sample();
        edge_sample();
        check("pre_arst_o4", o4, 1'b1);
        #2;
        clr_n = 1'b0;
        #1;
        check("arst_o4", o4, 1'b0);
        check("arst_t4", t4, 1'b0);
        check("arst_o1", o1, 1'b0);
        for (int i = 0; i < 2; i++) edge_sample();
        check("arst_hold_o4", o4, 1'b0);
        check("arst_hold_t4", t4, 1'b0);

        // After release, next rise exactly 4 edges later.
        @(negedge clk);
        clr_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            edge_sample();
            check($sformatf("rel_o4_e%0d", k), o4, logic'(k == 4));
            check($sformatf("rel_t4_e%0d", k), t4, logic'(k == 4));
        end

        // Long run DIV=5 over 1000 edges.
        @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        n_rise = 0;
        n_tick = 0;
        n_high = 0;
        prev_o = 1'b0;
        for (int k = 1; k <= 1000; k++) begin
            edge_sample();
            if (o5 && !prev_o) n_rise++;
            if (t5) n_tick++;
            if (o5) n_high++;
            prev_o = o5;
        end
        check_int("long_rises", n_rise, 100);
        check_int("long_ticks", n_tick, 100);
        check_int("long_high_cycles", n_high, 500);
        check("long_end_o5", o5, 1'b0);

`ifdef CLK_FOR_D0_RUNTIME_DIV_EN
        // Runtime divisor: 4 -> 2 mid half-period, then 0 -> half-period of 1.
        exp_ro = '{0,1,1,0,0,1,1,0,1,0,1};
        exp_rt = '{0,1,0,0,0,1,0,0,1,0,1};
        @(negedge clk);
        clr_n = 1'b0;
        dh4 = 4'd4;
        @(negedge clk);
        clr_n = 1'b1;
        edge_sample();
        edge_sample();
        @(negedge clk);
        dh4 = 4'd2;
        for (int k = 3; k <= 13; k++) begin
            edge_sample();
            check($sformatf("rt_o4_e%0d", k), o4, exp_ro[k]);
            check($sformatf("rt_t4_e%0d", k), t4, exp_rt[k]);
            if (k == 8) begin
                @(negedge clk);
                dh4 = 4'd0;
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_for_d0_gen.md
# clk_for_d0_gen

Clock-enable/divided-clock generator that derives a slow square wave `o` from the system clock. It drives the update rate of the single-digit 7-segment counter: the digit logic advances once per rising edge of `o`, or synchronously on `tick`. It is fully synchronous to `clk`, apart from an asynchronous reset.

## Interface
- `DIV`, default 25_000_000: half-period of `o` in `clk` cycles. Legal range 1 to 2^`CNT_W`-1.
- `CNT_W`, default 25: width of the internal counter. Must satisfy 2^`CNT_W` > `DIV`.
- `clk`, input, 1: system clock. All state changes on its rising edge.
- `clr_n`, input, 1: reset. Asynchronous, active-low.
- `o`, output, 1: divided square wave with period 2·`DIV` `clk` cycles and 50 % duty. Registered.
- `tick`, output, 1: one-`clk`-cycle pulse, high in the cycle in which `o` goes 0→1. Registered.
- `div_half`, input, `CNT_W`: runtime half-period. Present only when `CLK_FOR_D0_RUNTIME_DIV_EN` is defined.

## Operation
- Internal counter `cnt` is `CNT_W` bits wide. Internal active divisor `act` equals `DIV`, or the shadowed `div_half` when the feature is enabled.
- Each `clk` edge: if `cnt == act-1`, then `cnt` ← 0 and `o` ← ~`o`. Otherwise `cnt` ← `cnt`+1.
- `tick` ← (`cnt == act-1`) && (`o == 0`). `tick` is therefore high exactly in the cycle `o` is first high. It is low in all other cycles.
- `cnt` never exceeds `act-1`. No other state exists.
- `DIV = 1`: `o` toggles every cycle (clk/2), and `tick` is high every second cycle.
- Reset (`clr_n` low, at any time, including mid-count): `cnt` = 0, `o` = 0, `tick` = 0 immediately, without waiting for a clock edge. These values hold while `clr_n` is low.
- Runtime divisor (feature enabled):
  - At reset, `act` = `DIV`.
  - At each wrap (`cnt == act-1`), `act` ← `div_half`, or 1 if `div_half == 0`.
  - Changes to `div_half` therefore take effect only at a half-period boundary and never produce a runt pulse.

## Timing
- Latency from reset release:
  - Sample the first `clk` rising edge with `clr_n` high as edge 1.
  - At edge `DIV`, `o` rises and `tick` rises.
  - At edge 2·`DIV`, `o` falls.
  - At edge 3·`DIV`, `o` rises again, and so on.
- `tick` lasts exactly one `clk` cycle per period of `o`.
- Reset removal is not synchronized internally. The integrator guarantees release meets recovery/removal timing with respect to `clk`.
- Simultaneous wrap and `div_half` change: the value of `div_half` sampled at the wrap edge is the one loaded.

## Configuration
- Macro `CLK_FOR_D0_RUNTIME_DIV_EN`.
- Defined: the `div_half` port exists, and the half-period is runtime-programmable through the shadow `act` register described under Operation.
- Undefined: no `div_half` port, `act` is the constant `DIV`, and no shadow register is built.

## Test plan
- Reset: with `DIV`=4, hold `clr_n`=0 for 3 cycles, then assert `clr_n`=0 asynchronously mid-cycle while `o`=1 → `o`=0, `tick`=0 immediately; no toggle while low.
- Basic divide: `DIV`=4, release reset → `o` = 0,0,0,1,1,1,1,0,0,0,0,1… on edges 1..12 (period 8); `tick`=1 only at edges 4 and 12.
- Minimum divide: `DIV`=1 → `o` toggles every edge; `tick` high on alternate cycles aligned with `o` rising.
- Long run: `DIV`=5, 1000 cycles → exactly 100 `o` periods, 100 `tick` pulses, duty 5/5.
- Runtime divisor (macro defined, `DIV`=4): change `div_half` 4→2 mid-half-period → the current half-period still lasts 4 cycles, subsequent half-periods last 2; `div_half`=0 → half-period of 1.
- Mid-count reset: reset at `cnt`=2 with `DIV`=4 → after release, the next `o` rise occurs exactly 4 edges later.
